// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
//   Shared definitions for the boot loader front end: default character width
//   and clock frequency, the line-ending characters the hex parser also keys
//   on, the receive FSM state type and the bit-period helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam int unsigned char_width_default   = 8;
    localparam int unsigned clk_frequency_default = 50_000_000;

    // Line terminators shared with the boot hex parser.
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Receive FSM states. BREAK holds off new frames while the line sits low
    // after a framing error.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Bit period in clk cycles, rounded to the nearest integer.
    function automatic int unsigned calc_bit_cycles(input int unsigned clk_frequency,
                                                    input int unsigned baud_rate);
        return (clk_frequency + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/boot_rx_synchronizer.sv
// -----------------------------------------------------------------------------
// boot_rx_synchronizer
//   Multi-flop synchronizer bringing the asynchronous rx line into the clk
//   domain. All flops reset to 1 so that reset looks like an idle line and
//   never fakes a start bit.
// Ports
//   clk    in   1  clock
//   reset  in   1  asynchronous, active-high reset
//   rx     in   1  raw serial line, asynchronous to clk
//   rx_s   out  1  synchronized serial line
// -----------------------------------------------------------------------------
module boot_rx_synchronizer #(
    parameter int unsigned sync_stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    if (sync_stages < 2) begin : g_sync_stages_check
        $error("boot_rx_synchronizer: sync_stages must be >= 2");
    end

    logic [sync_stages-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], rx};
        end
    end

    assign rx_s = sync_q[sync_stages-1];

endmodule

// File: rtl/boot_uart_receiver.sv
// -----------------------------------------------------------------------------
// boot_uart_receiver
//   Serial front end of the boot loader. Oversamples the 8N1 (LSB first) rx
//   line, samples every bit at its centre and hands each correctly framed
//   character to the boot hex parser as a one-cycle pulse. A low stop bit
//   produces a one-cycle framing_error pulse instead, after which the receiver
//   waits for the line to return high before looking for a new start bit.
//
// Output handshake: out_valid and framing_error are push-only strobes with no
//   ready; the consumer must take every pulse. out_char is updated only on the
//   cycle out_valid is high and holds until the next out_valid. out_valid and
//   framing_error are never high together.
//
// Ports
//   clk            in   1           clock, all logic on posedge
//   reset          in   1           asynchronous, active-high reset
//   rx             in   1           raw serial line, idle high, async to clk
//   out_valid      out  1           one-cycle pulse: new character on out_char
//   out_char       out  char_width  last correctly framed character
//   framing_error  out  1           one-cycle pulse: stop bit low, char dropped
//   busy           out  1           high while a frame is in progress
//   dbg_state      out  3           current FSM state (rx_state_t encoding)
// -----------------------------------------------------------------------------
module boot_uart_receiver
    import boot_pkg::*;
#(
    parameter int unsigned clk_frequency = clk_frequency_default,
    parameter int unsigned baud_rate     = 115_200,
    parameter int unsigned char_width    = char_width_default,
    parameter int unsigned sync_stages   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  out_valid,
    output logic [char_width-1:0] out_char,
    output logic                  framing_error,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    localparam int unsigned bit_cycles  = calc_bit_cycles(clk_frequency, baud_rate);
    localparam int unsigned half_cycles = bit_cycles / 2;
    localparam int unsigned cnt_w       = $clog2(bit_cycles + 1);
    localparam int unsigned idx_w       = (char_width > 1) ? $clog2(char_width) : 1;

    // Terminal counts: the counter runs 0..N-1 and the sample is taken on the
    // cycle it sits at N-1, so each phase lasts exactly N cycles.
    localparam logic [cnt_w-1:0] bit_last  = cnt_w'(bit_cycles - 1);
    localparam logic [cnt_w-1:0] half_last = cnt_w'(half_cycles - 1);
    localparam logic [idx_w-1:0] idx_last  = idx_w'(char_width - 1);
    localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
    localparam logic [idx_w-1:0] idx_one   = idx_w'(1);

    if (bit_cycles < 4) begin : g_bit_cycles_check
        $error("boot_uart_receiver: bit_cycles must be >= 4");
    end

    if (char_width < 2) begin : g_char_width_check
        $error("boot_uart_receiver: char_width must be >= 2");
    end

    // -------------------------------------------------------------------------
    // rx synchronizer: the FSM only ever looks at rx_s.
    // -------------------------------------------------------------------------
    logic rx_s;

    boot_rx_synchronizer #(
        .sync_stages (sync_stages)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    // -------------------------------------------------------------------------
    // Receive FSM with bit counter, bit index and shift register.
    // -------------------------------------------------------------------------
    rx_state_t             state;
    logic [cnt_w-1:0]      count;
    logic [idx_w-1:0]      bit_idx;
    logic [char_width-1:0] shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            out_char      <= '0;
            out_valid     <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Both event strobes last a single cycle.
            out_valid     <= 1'b0;
            framing_error <= 1'b0;

            case (state)
                IDLE: begin
                    count <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                // Re-check the line half a bit later: a high level there means
                // the falling edge was a glitch, not a start bit.
                START: begin
                    if (count == half_last) begin
                        count <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        count <= count + cnt_one;
                    end
                end

                // Data arrives LSB first, so each new bit enters at the MSB end
                // and the first bit ends up in bit 0 after char_width shifts.
                DATA: begin
                    if (count == bit_last) begin
                        count <= '0;
                        shift <= {rx_s, shift[char_width-1:1]};
                        if (bit_idx == idx_last) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + idx_one;
                        end
                    end else begin
                        count <= count + cnt_one;
                    end
                end

                // Leaving at the stop-bit centre puts us back in IDLE half a
                // bit early, so a start bit that follows immediately is seen.
                STOP: begin
                    if (count == bit_last) begin
                        count <= '0;
                        if (rx_s) begin
                            out_char  <= shift;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        count <= count + cnt_one;
                    end
                end

                // A line held low (break) must not be read as endless frames.
                BREAK: begin
                    count <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_boot_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_boot_uart_receiver
//   Directed bench for boot_uart_receiver with clk_frequency=16, baud_rate=1,
//   giving a 16-cycle bit period. The model is a queue of the events a correct
//   receiver must produce for the frames sent (a character, or a framing error),
//   plus the character out_char must hold between events.
// -----------------------------------------------------------------------------
module tb_boot_uart_receiver;

    localparam int unsigned bit_p = 16;

    // ---------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       out_valid;
    logic [7:0] out_char;
    logic       framing_error;
    logic       busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    boot_uart_receiver #(
        .clk_frequency (16),
        .baud_rate     (1),
        .char_width    (8),
        .sync_stages   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .out_valid     (out_valid),
        .out_char      (out_char),
        .framing_error (framing_error),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- scoreboard
    // exp_q entries: bit 8 = framing error expected, bits 7:0 = character.
    logic [8:0] exp_q[$];
    logic [7:0] model_char = 8'h00;
    int         lat_fall   = -1;
    int         total      = 0;
    int         bad        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [8:0] e;
        int         lat;
        if (reset) begin
            model_char = 8'h00;
        end else begin
            check("valid_and_ferr_exclusive", {31'd0, out_valid & framing_error}, 32'd0);
            if (out_valid || framing_error) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: out_valid=%0b framing_error=%0b out_char=%0h required=no event",
                             out_valid, framing_error, out_char);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {23'd0, framing_error, (out_valid ? out_char : 8'h00)}, {23'd0, e});
                    if (out_valid) model_char = e[7:0];
                    if (out_valid && lat_fall >= 0) begin
                        // Counted from the first clock edge that sees the low rx.
                        lat = cyc - lat_fall - 1;
                        total++;
                        if (lat < 152 || lat > 154) begin
                            bad++;
                            $display("FAIL latency: actual=%0d required=152..154", lat);
                        end
                        lat_fall = -1;
                    end
                end
            end
            check("out_char_hold", {24'd0, out_char}, {24'd0, model_char});
        end
    end

    // ---------------------------------------------------------------- drivers
    // All driving happens 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] ch, input logic stop_v, input int period);
        rx = 1'b0;
        tick(period);
        for (int i = 0; i < 8; i++) begin
            rx = ch[i];
            tick(period);
        end
        rx = stop_v;
        tick(period);
    endtask

    task automatic send_char(input logic [7:0] ch, input int period);
        exp_q.push_back({1'b0, ch});
        send_bits(ch, 1'b1, period);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        reset = 1'b1;
        rx    = 1'b1;
        tick(3);

        // Reset state.
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 0);
        check("reset_out_char", {24'd0, out_char}, 0);
        check("reset_framing_error", {31'd0, framing_error}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(10);

        // 1. Single 'A' with latency check and busy mid-frame.
        lat_fall = cyc;
        fork
            send_char(8'h41, bit_p);
            begin
                tick(40);
                @(negedge clk);
                check("t1_busy_mid_frame", {31'd0, busy}, 1);
            end
        join
        drain("t1_drain", 60);
        tick(20);

        // 2. "0F\r\n" back to back, one stop bit each.
        send_char(8'h30, bit_p);
        send_char(8'h46, bit_p);
        send_char(8'h0D, bit_p);
        send_char(8'h0A, bit_p);
        drain("t2_drain", 60);
        tick(20);

        // 3. Five-cycle glitch, then 'U'.
        rx = 1'b0;
        tick(4);
        @(negedge clk);
        check("t3_busy_during_glitch", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        rx = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t3_busy_cleared", {31'd0, busy}, 0);
        tick(20);
        send_char(8'h55, bit_p);
        drain("t3_drain", 60);
        tick(20);

        // 4. 8'hA5 with low stop bit, line held low 48 more cycles, then 8'h3C.
        exp_q.push_back({1'b1, 8'h00});
        send_bits(8'hA5, 1'b0, bit_p);
        tick(24);
        @(negedge clk);
        check("t4_busy_during_break", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        tick(23);
        rx = 1'b1;
        tick(20);
        check("t4_ferr_seen", exp_q.size(), 0);
        send_char(8'h3C, bit_p);
        drain("t4_drain", 60);
        tick(20);

        // 5. Reset in the middle of data bit 4 of 8'hFF, then 8'h12.
        rx = 1'b0;
        tick(bit_p);
        rx = 1'b1;
        tick(bit_p * 4 + bit_p / 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_out_valid", {31'd0, out_valid}, 0);
        check("t5_reset_out_char", {24'd0, out_char}, 0);
        check("t5_reset_framing_error", {31'd0, framing_error}, 0);
        check("t5_reset_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(bit_p * 4 + 20);
        send_char(8'h12, bit_p);
        drain("t5_drain", 60);
        tick(20);

        // 6. 8'hC3 at -6% and +6% bit period.
        send_char(8'hC3, 15);
        drain("t6_fast_drain", 60);
        tick(20);
        send_char(8'hC3, 17);
        drain("t6_slow_drain", 60);
        tick(40);

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
